// File: rtl/ascon_pack.sv
// Shared Ascon definitions: the 320-bit state type, round constants, schedule
// encodings and the FSM state type used by the permutation sequencer.
package ascon_pack;

    // Word i of the Ascon state lives in element [i] (x0 is least significant).
    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_RUN  = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_t;

    localparam logic [1:0] MODE_P12 = 2'b00;
    localparam logic [1:0] MODE_P6  = 2'b01;
    localparam logic [1:0] MODE_P8  = 2'b10;

    localparam logic [3:0] ROUND_LAST = 4'd11;

    localparam logic [7:0] round_constant [0:11] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    // A schedule of N rounds always ends on index 11, so it starts at 12-N.
    function automatic logic [3:0] first_round(input logic [1:0] mode,
                                               input int rounds_a,
                                               input int rounds_b,
                                               input int rounds_c);
        case (mode)
            MODE_P6: return 4'(12 - rounds_b);
            MODE_P8: return 4'(12 - rounds_c);
            default: return 4'(12 - rounds_a);
        endcase
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] value,
                                          input int unsigned amount);
        return (value >> amount) | (value << (64 - amount));
    endfunction

endpackage

// File: rtl/permutation_round.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer across
// the 64 bit-slices, then the per-word linear diffusion.
module permutation_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    logic [7:0] rc;
    type_state  added;
    type_state  substituted;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] a0, a1, a2, a3, a4;

    always_comb begin
        rc = 8'h00;
        if (round_i <= ROUND_LAST) begin
            rc = round_constant[round_i];
        end
        added    = state_i;
        added[2] = state_i[2] ^ {56'd0, rc};
    end

    // Bitsliced S-box: pre-mix, chi-like nonlinear step, post-mix, complement.
    always_comb begin
        a0 = added[0] ^ added[4];
        a4 = added[4] ^ added[3];
        a2 = added[2] ^ added[1];
        a1 = added[1];
        a3 = added[3];

        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;

        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;

        substituted[1] = a1 ^ a0;
        substituted[0] = a0 ^ a4;
        substituted[3] = a3 ^ a2;
        substituted[2] = ~a2;
        substituted[4] = a4;
    end

    always_comb begin
        state_o[0] = substituted[0] ^ ror64(substituted[0], 19) ^ ror64(substituted[0], 28);
        state_o[1] = substituted[1] ^ ror64(substituted[1], 61) ^ ror64(substituted[1], 39);
        state_o[2] = substituted[2] ^ ror64(substituted[2], 1)  ^ ror64(substituted[2], 6);
        state_o[3] = substituted[3] ^ ror64(substituted[3], 10) ^ ror64(substituted[3], 17);
        state_o[4] = substituted[4] ^ ror64(substituted[4], 7)  ^ ror64(substituted[4], 41);
    end

endmodule

// File: rtl/ascon_perm_sequencer.sv
// Iterative Ascon permutation: applies one round per clock to a 320-bit state
// register, with a start/done handshake and selectable 12/6/8-round schedules.
module ascon_perm_sequencer
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6,
    parameter int ROUNDS_C = 8
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] mode_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       done_o
);

    seq_state_t fsm;
    seq_state_t fsm_next;
    type_state  state_reg;
    type_state  round_out;
    logic [3:0] round_cnt;
    logic       accept;
    logic       advance;

    permutation_round u_round (
        .state_i (state_reg),
        .round_i (round_cnt),
        .state_o (round_out)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm <= SEQ_IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // DONE accepts a new start just like IDLE, giving back-to-back runs.
    always_comb begin
        fsm_next = fsm;
        accept   = 1'b0;
        advance  = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (fsm)
            SEQ_IDLE: begin
                if (start_i) begin
                    accept   = 1'b1;
                    fsm_next = SEQ_LOAD;
                end
            end
            SEQ_LOAD: begin
                busy_o   = 1'b1;
                fsm_next = SEQ_RUN;
            end
            SEQ_RUN: begin
                busy_o  = 1'b1;
                advance = 1'b1;
                if (round_cnt == ROUND_LAST) begin
                    fsm_next = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    accept   = 1'b1;
                    fsm_next = SEQ_LOAD;
                end else begin
                    fsm_next = SEQ_IDLE;
                end
            end
            default: fsm_next = SEQ_IDLE;
        endcase
    end

    // The counter captures the schedule at acceptance, which is what latches
    // the mode: later mode_i changes never reach the running permutation.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= '0;
            round_cnt <= 4'd0;
        end else if (accept) begin
            state_reg <= state_i;
            round_cnt <= first_round(mode_i, ROUNDS_A, ROUNDS_B, ROUNDS_C);
        end else if (advance) begin
            state_reg <= round_out;
            if (round_cnt != ROUND_LAST) begin
                round_cnt <= round_cnt + 4'd1;
            end
        end
    end

    assign state_o = state_reg;
    assign round_o = round_cnt;

endmodule
